// File: rtl/systolic_host_if.sv
// systolic_host_if
// Host-side stream adapter for the output-stationary systolic array.
// Loads the top operand then the left operand from a valid/ready word stream,
// pulses array_start, waits for matrix_rdy under a watchdog, captures the
// result into a local buffer and streams it back out with out_last on the
// final word.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_data    : operand word stream (top words, then left)
//   top_matrix, left_matrix      : assembled operand buses to the array
//   array_start     : one-cycle start pulse to the array
//   matrix_rdy, output_matrix    : array result handshake (level) and data
//   out_valid/out_ready/out_data/out_last : result word stream
//   busy            : high while running or draining
//   timeout_err     : sticky watchdog flag, cleared by the next load
module systolic_host_if #(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_SIZE-1:0]            in_data,
    output logic [ROWS*COLS*WORD_SIZE-1:0]  top_matrix,
    output logic [ROWS*COLS*WORD_SIZE-1:0]  left_matrix,
    output logic                            array_start,
    input  logic                            matrix_rdy,
    input  logic [ROWS*COLS*WORD_SIZE-1:0]  output_matrix,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_SIZE-1:0]            out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int unsigned N       = ROWS * COLS;
    localparam int unsigned BUS_W   = N * WORD_SIZE;
    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD_TOP  = 2'd0,
        S_LOAD_LEFT = 2'd1,
        S_RUN       = 2'd2,
        S_DRAIN     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BUS_W-1:0]   top_q,   top_d;
    logic [BUS_W-1:0]   left_q,  left_d;
    logic [BUS_W-1:0]   buf_q,   buf_d;
    logic               tout_q,  tout_d;

    logic               idx_at_last;

    assign idx_at_last = (idx_q == IDX_LAST);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD_TOP;
            idx_q   <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
            left_q  <= '0;
            buf_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            left_q  <= left_d;
            buf_q   <= buf_d;
            tout_q  <= tout_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
        left_d  = left_q;
        buf_d   = buf_q;
        tout_d  = tout_q;

        unique case (state_q)
            S_LOAD_TOP: begin
                if (in_valid) begin
                    top_d[32'(idx_q) * WORD_SIZE +: WORD_SIZE] = in_data;
                    // A new transaction acknowledges any earlier watchdog trip
                    if (idx_q == '0) begin
                        tout_d = 1'b0;
                    end
                    if (idx_at_last) begin
                        idx_d   = '0;
                        state_d = S_LOAD_LEFT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_LOAD_LEFT: begin
                if (in_valid) begin
                    left_d[32'(idx_q) * WORD_SIZE +: WORD_SIZE] = in_data;
                    if (idx_at_last) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_RUN: begin
                // cnt_q == 0 is the start cycle; a ready still asserted from
                // the previous job must not be mistaken for this result.
                if ((cnt_q != '0) && matrix_rdy) begin
                    buf_d   = output_matrix;
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    tout_d  = 1'b1;
                    idx_d   = '0;
                    state_d = S_LOAD_TOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_at_last) begin
                        idx_d   = '0;
                        state_d = S_LOAD_TOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_LOAD_TOP;
                idx_d   = '0;
            end
        endcase
    end

    // Result word select; zero outside DRAIN
    always_comb begin
        out_data = '0;
        if (state_q == S_DRAIN) begin
            out_data = buf_q[32'(idx_q) * WORD_SIZE +: WORD_SIZE];
        end
    end

    // Handshake and status decodes of registered state only
    assign in_ready    = (state_q == S_LOAD_TOP) || (state_q == S_LOAD_LEFT);
    assign array_start = (state_q == S_RUN) && (cnt_q == '0);
    assign out_valid   = (state_q == S_DRAIN);
    assign out_last    = (state_q == S_DRAIN) && idx_at_last;
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign timeout_err = tout_q;
    assign top_matrix  = top_q;
    assign left_matrix = left_q;

endmodule

// File: tb/tb_systolic_host_if.sv
`timescale 1ns/1ps
// Bench for systolic_host_if: two instances (long and short watchdog) share
// the stream stimulus; each has its own array model driving matrix_rdy.
module tb_systolic_host_if;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 16;
    localparam int unsigned BW = N * W;
    localparam int TO_A = 1024;
    localparam int TO_T = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_ready;
    logic [1:0]    mrdy;
    logic [BW-1:0] omat;

    logic [1:0]    in_ready_w, start_w, ov_w, ol_w, busy_w, to_w;
    logic [W-1:0]  od_w   [2];
    logic [BW-1:0] top_w  [2];
    logic [BW-1:0] left_w [2];

    always #5 clk = ~clk;

    systolic_host_if #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .TIMEOUT_CYCLES(TO_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .top_matrix(top_w[0]), .left_matrix(left_w[0]),
        .array_start(start_w[0]), .matrix_rdy(mrdy[0]), .output_matrix(omat),
        .out_valid(ov_w[0]), .out_ready(out_ready), .out_data(od_w[0]),
        .out_last(ol_w[0]), .busy(busy_w[0]), .timeout_err(to_w[0]));

    systolic_host_if #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .TIMEOUT_CYCLES(TO_T)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .top_matrix(top_w[1]), .left_matrix(left_w[1]),
        .array_start(start_w[1]), .matrix_rdy(mrdy[1]), .output_matrix(omat),
        .out_valid(ov_w[1]), .out_ready(out_ready), .out_data(od_w[1]),
        .out_last(ol_w[1]), .busy(busy_w[1]), .timeout_err(to_w[1]));

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int i, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h", nm, i, act, exp);
        end
    endtask

    // ---------------- behavioural model (transaction phases) ----------------
    // ph: 0 = collecting top words, 1 = collecting left words,
    //     2 = waiting on the array, 3 = returning result words
    int           ph [2];
    int           k  [2];
    int           rc [2];
    int           to_lim [2] = '{TO_A, TO_T};
    logic [W-1:0] mt [2][N];
    logic [W-1:0] ml [2][N];
    logic [W-1:0] mb [2][N];
    bit           mto [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; k[i] = 0; rc[i] = 0; mto[i] = 1'b0;
            for (int j = 0; j < N; j++) begin
                mt[i][j] = '0; ml[i][j] = '0; mb[i][j] = '0;
            end
        end
    endtask

    task automatic model_step(input int i);
        case (ph[i])
            0, 1: if (in_valid) begin
                if (ph[i] == 0) begin
                    if (k[i] == 0) mto[i] = 1'b0;
                    mt[i][k[i]] = in_data;
                end else begin
                    ml[i][k[i]] = in_data;
                end
                k[i]++;
                if (k[i] == N) begin
                    k[i] = 0; ph[i]++; rc[i] = 0;
                end
            end
            2: begin
                if (rc[i] > 0 && mrdy[i]) begin
                    for (int j = 0; j < N; j++) mb[i][j] = omat[j*W +: W];
                    k[i] = 0; ph[i] = 3;
                end else if (rc[i] == to_lim[i] - 1) begin
                    mto[i] = 1'b1; ph[i] = 0; k[i] = 0;
                end else begin
                    rc[i]++;
                end
            end
            default: if (out_ready) begin
                k[i]++;
                if (k[i] == N) begin
                    k[i] = 0; ph[i] = 0;
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i);
    end

    function automatic logic [BW-1:0] pack_model(input int i, input bit left);
        logic [BW-1:0] r = '0;
        for (int j = 0; j < N; j++) r[j*W +: W] = left ? ml[i][j] : mt[i][j];
        return r;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                check("in_ready",    i, BW'(in_ready_w[i]), BW'(ph[i] < 2));
                check("array_start", i, BW'(start_w[i]),    BW'(ph[i] == 2 && rc[i] == 0));
                check("out_valid",   i, BW'(ov_w[i]),       BW'(ph[i] == 3));
                check("out_last",    i, BW'(ol_w[i]),       BW'(ph[i] == 3 && k[i] == N - 1));
                check("busy",        i, BW'(busy_w[i]),     BW'(ph[i] >= 2));
                check("timeout_err", i, BW'(to_w[i]),       BW'(mto[i]));
                check("top_matrix",  i, top_w[i],  pack_model(i, 1'b0));
                check("left_matrix", i, left_w[i], pack_model(i, 1'b1));
                if (ph[i] == 3) check("out_data", i, BW'(od_w[i]), BW'(mb[i][k[i]]));
            end
        end
    end

    // ---------------- array model and downstream ready ----------------
    int lat  [2] = '{-1, -1};
    int acnt [2] = '{-1, -1};
    int or_mode = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            acnt[0] = -1; acnt[1] = -1; mrdy = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start_w[i]) acnt[i] = 0;
                else if (acnt[i] >= 0) acnt[i]++;
                if (!busy_w[i] || ov_w[i]) acnt[i] = -1;
                mrdy[i] = (lat[i] >= 0) && (acnt[i] >= lat[i]);
            end
            // Array result changes after capture must not reach the drain
            if (ov_w[0] || ov_w[1])
                for (int j = 0; j < N; j++) omat[j*W +: W] = W'($urandom);
        end
    end

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- observation counters ----------------
    int           starts [2], busy_cyc [2], ov_cnt [2], ndrained [2], lasts [2], last_at [2];
    int           st_cyc [2], ov_cyc [2];
    logic [W-1:0] got0 [$];

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (start_w[i]) begin
                    starts[i]++;
                    if (st_cyc[i] < 0) st_cyc[i] = cyc;
                end
                if (busy_w[i]) busy_cyc[i]++;
                if (ov_w[i]) begin
                    ov_cnt[i]++;
                    if (ov_cyc[i] < 0) ov_cyc[i] = cyc;
                end
                if (ov_w[i] && out_ready) begin
                    if (i == 0) got0.push_back(od_w[i]);
                    if (ol_w[i]) begin lasts[i]++; last_at[i] = ndrained[i]; end
                    ndrained[i]++;
                end
            end
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            starts[i] = 0; busy_cyc[i] = 0; ov_cnt[i] = 0; ndrained[i] = 0;
            lasts[i] = 0; last_at[i] = -1; st_cyc[i] = -1; ov_cyc[i] = -1;
        end
        got0.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    logic [W-1:0] stim [2*N];

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        clear_stats();
    endtask

    task automatic load(input bit gaps);
        for (int j = 0; j < 2 * N; j++) begin
            while (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0; in_data = W'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = stim[j];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(ph[0] == 0 && ph[1] == 0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout got busy after %0d cycles want idle", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_known();
        for (int j = 0; j < N; j++) begin
            stim[j]     = W'(16'h0001 + j);
            stim[N + j] = W'(16'h0101 + j);
            omat[j*W +: W] = W'(16'hA000 + j);
        end
    endtask

    task automatic set_random();
        for (int j = 0; j < 2 * N; j++) stim[j] = W'($urandom);
        for (int j = 0; j < N; j++) omat[j*W +: W] = W'($urandom);
    endtask

    task automatic check_known_drain();
        check("drain_count", 0, BW'(got0.size()), BW'(N));
        for (int j = 0; j < N && j < got0.size(); j++)
            check("drain_word", 0, BW'(got0[j]), BW'(16'hA000 + j));
        check("last_count", 0, BW'(lasts[0]), BW'(1));
        check("last_pos",   0, BW'(last_at[0]), BW'(N - 1));
    endtask

    task automatic check_reset_values();
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", i, BW'(in_ready_w[i]), BW'(1));
            check("rst_start",    i, BW'(start_w[i]), '0);
            check("rst_ov",       i, BW'(ov_w[i]), '0);
            check("rst_last",     i, BW'(ol_w[i]), '0);
            check("rst_od",       i, BW'(od_w[i]), '0);
            check("rst_busy",     i, BW'(busy_w[i]), '0);
            check("rst_to",       i, BW'(to_w[i]), '0);
            check("rst_top",      i, top_w[i], '0);
            check("rst_left",     i, left_w[i], '0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; omat = '0; mrdy = '0; out_ready = 1'b1;
        clear_stats();
        #1 rst = 1'b0;
        #2 check_reset_values();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        clear_stats();

        // Basic transaction; latency 12 also trips the 8-cycle watchdog copy
        set_known(); lat[0] = 12; lat[1] = 12; or_mode = 0;
        load(1'b0);
        check("top_lo", 0, BW'(top_w[0][15:0]),    BW'(16'h0001));
        check("top_hi", 0, BW'(top_w[0][255:240]), BW'(16'h0010));
        check("left_lo", 0, BW'(left_w[0][15:0]),  BW'(16'h0101));
        wait_idle(200);
        check("start_pulses", 0, BW'(starts[0]), BW'(1));
        check_known_drain();
        check("busy_after", 0, BW'(busy_w[0]), '0);
        check("short_wd_to", 1, BW'(to_w[1]), BW'(1));
        check("short_wd_nodrain", 1, BW'(ov_cnt[1]), '0);

        // Back-pressure with load gaps
        do_reset();
        set_known(); lat[0] = 3; lat[1] = 3; or_mode = 1;
        load(1'b1);
        check("gap_top",  0, top_w[0][15:0] == 16'h0001 && top_w[0][255:240] == 16'h0010 ? BW'(1) : '0, BW'(1));
        check("gap_left", 0, BW'(left_w[0][255:240]), BW'(16'h0110));
        wait_idle(300);
        check_known_drain();

        // Ready already high in the start cycle
        do_reset();
        set_known(); lat[0] = 0; lat[1] = 0; or_mode = 0;
        load(1'b0);
        wait_idle(200);
        check("early_rdy_gap", 0, BW'(ov_cyc[0] - st_cyc[0]), BW'(2));
        check_known_drain();

        // Watchdog: no ready at all
        do_reset();
        set_random(); lat[0] = -1; lat[1] = -1; or_mode = 0;
        load(1'b0);
        repeat (12) begin @(posedge clk); #1; end
        check("to_run_cycles", 1, BW'(busy_cyc[1]), BW'(TO_T));
        check("to_flag",       1, BW'(to_w[1]), BW'(1));
        check("to_in_ready",   1, BW'(in_ready_w[1]), BW'(1));
        check("to_no_ov",      1, BW'(ov_cnt[1]), '0);
        in_valid = 1'b1; in_data = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("to_cleared", 1, BW'(to_w[1]), '0);

        // Ready arrives exactly on the last watchdog cycle
        do_reset();
        set_known(); lat[0] = TO_T - 1; lat[1] = TO_T - 1; or_mode = 0;
        load(1'b0);
        wait_idle(200);
        check("tie_no_to",  1, BW'(to_w[1]), '0);
        check("tie_drain",  1, BW'(ndrained[1]), BW'(N));

        // Reset after five drained words, then a fresh transaction
        do_reset();
        set_random(); lat[0] = 4; lat[1] = 4; or_mode = 0;
        load(1'b0);
        n = 0;
        while (ndrained[0] < 5 && n < 100) begin @(negedge clk); n++; end
        check("mid_reached", 0, BW'(n < 100), BW'(1));
        @(posedge clk); #2 rst = 1'b0;
        #1 check_reset_values();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        clear_stats();
        set_known(); lat[0] = 5; lat[1] = 5;
        load(1'b0);
        wait_idle(200);
        check_known_drain();

        // Randomized transactions, back to back
        for (int t = 0; t < 6; t++) begin
            set_random();
            lat[0] = $urandom_range(1, 10); lat[1] = lat[0]; or_mode = 2;
            load(1'b1);
            wait_idle(400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_host_if.md
# systolic_host_if

Host-side stream adapter for the output-stationary BISR systolic top level. It accepts a valid/ready word stream carrying the top and left operand matrices and assembles them into the flat `top_matrix`/`left_matrix` buses. It then pulses a start to the array, waits for `matrix_rdy` under a watchdog, and captures `output_matrix`. Finally it streams the result back out word by word with `out_last` on the final word.

## Interface
- `ROWS`, 4, matrix rows.
- `COLS`, 4, matrix columns.
- `WORD_SIZE`, 16, bits per element.
- `TIMEOUT_CYCLES`, 1024, maximum cycles allowed in RUN for `matrix_rdy`. Must be at least 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid` and `in_ready` are both high.
- `in_data`  in  WORD_SIZE  input element.
- `top_matrix`  out  ROWS*COLS*WORD_SIZE  assembled top operand, to the array.
- `left_matrix`  out  ROWS*COLS*WORD_SIZE  assembled left operand, to the array.
- `array_start`  out  1  one-cycle start pulse to the array.
- `matrix_rdy`  in  1  array result valid (level).
- `output_matrix`  in  ROWS*COLS*WORD_SIZE  array result.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the output word.
- `out_data`  out  WORD_SIZE  result element.
- `out_last`  out  1  high with the final result word.
- `busy`  out  1  high in RUN or DRAIN.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Let N = ROWS*COLS. Word index k maps to bits `[k*WORD_SIZE +: WORD_SIZE]` of the corresponding bus. Index 0 is the first word transferred.
- **LOAD_TOP** (reset state):
  - `in_ready`=1.
  - Each accepted word writes `top_matrix` slot `idx`, then `idx` increments.
  - On the accept with `idx`=N-1: `idx`←0, go to LOAD_LEFT.
  - The first accepted word also clears `timeout_err`.
- **LOAD_LEFT**: same behaviour, writing `left_matrix`. On the accept with `idx`=N-1, go to RUN.
- **RUN**:
  - `in_ready`=0.
  - `array_start`=1 in the first RUN cycle only.
  - The watchdog counter is cleared on entry and increments every RUN cycle.
  - `matrix_rdy` is ignored in the `array_start` cycle.
  - In any later RUN cycle with `matrix_rdy`=1:
    - Capture `output_matrix` into an internal result buffer.
    - `idx`←0.
    - Go to DRAIN.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1:
    - Set `timeout_err`=1.
    - Go to LOAD_TOP.
    - Discard the result.
  - If `matrix_rdy` and the timeout occur in the same cycle, `matrix_rdy` wins (capture, no error).
- **DRAIN**:
  - `out_valid`=1.
  - `out_data` = buffer slot `idx`.
  - `out_last` = (`idx`==N-1).
  - On `out_valid` and `out_ready`: `idx` increments. After the last word, go to LOAD_TOP.
- `top_matrix` and `left_matrix` hold their values from the final load word until overwritten by the next load. They are stable throughout RUN and DRAIN.
- The buffer decouples the array: `output_matrix`/`matrix_rdy` may change after capture without affecting DRAIN.
- `in_data` is not accepted in RUN or DRAIN, because `in_ready`=0.
- `out_valid` is 0 outside DRAIN.

## Timing
- Reset values (while `rst`=0):
  - state=LOAD_TOP, `idx`=0, counter=0.
  - `in_ready`=1 (decoded from state).
  - `top_matrix`=0, `left_matrix`=0, buffer=0.
  - `array_start`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
  - `busy`=0, `timeout_err`=0.
- `in_ready`, `out_valid`, `out_last`, `busy` and `array_start` are pure decodes of registered state and `idx`. There is no combinational path from `in_valid` or `out_ready`.
- The last left word is accepted at edge T. `array_start` is high in cycle T+1. `matrix_rdy` is first honoured at cycle T+2.
- `matrix_rdy` sampled high at edge R gives `out_valid`=1 in cycle R+1, with word 0 on `out_data`.
- Output handshake rules:
  - `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - With `out_ready` held high, one word moves per cycle and N words take N cycles.
- Throughput: a full transaction takes at minimum 2N (load) + 1 (start) + array latency + N (drain) cycles. Load sustains one word per cycle.
- Reset mid-operation: an asynchronous return to reset values. Any partially loaded or drained matrix is abandoned.
- Back-pressure on load (`in_valid` gaps) only stalls `idx`. No timeout applies in the LOAD states.

## Test plan
- **Basic transaction** (ROWS=COLS=4, WORD_SIZE=16):
  - Stimulus: load top = 0x0001..0x0010, left = 0x0101..0x0110. The bench array model asserts `matrix_rdy` 12 cycles after `array_start`, with `output_matrix` word k = 0xA000+k.
  - Required: `top_matrix`[15:0]=0x0001 and `top_matrix`[255:240]=0x0010; `array_start` exactly one pulse.
  - Required: `out_data` 0xA000..0xA00F in order; `out_last` only on 0xA00F; `busy` low after.
- **Back-pressure**:
  - Stimulus: toggle `out_ready` 1,0,0,1 repeating during DRAIN.
  - Required: no word dropped or duplicated; `out_data` stable in stall cycles; `in_valid` gaps during load give identical matrices.
- **Early/stale `matrix_rdy`**:
  - Stimulus: hold `matrix_rdy`=1 from the start of RUN.
  - Required: capture occurs at the cycle after `array_start`, not in it.
- **Timeout** (TIMEOUT_CYCLES=8):
  - Stimulus: never assert `matrix_rdy`.
  - Required: `timeout_err`=1 after 8 RUN cycles; state returns to LOAD_TOP (`in_ready`=1, `out_valid` never 1); the next accepted word clears `timeout_err`.
- **Timeout tie**:
  - Stimulus: `matrix_rdy` arrives exactly in the cycle where the counter = TIMEOUT_CYCLES-1.
  - Required: DRAIN entered, `timeout_err` stays 0.
- **Reset mid-operation**:
  - Stimulus: assert `rst`=0 after 5 of 16 drained words.
  - Required: all outputs at reset values immediately (asynchronous); a fresh transaction afterwards completes correctly.
